// File: rtl/result_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : result_serializer_pkg
// Brief   : Shared types and constants for the result serializer slice.
// Rev     : 1.0 - initial release
// ============================================================================
package result_serializer_pkg;

    localparam int RS_WIDTH = 33;

    // x^33 + x^13 + 1
    localparam logic [32:0] MISR_POLY = 33'h0_0000_2001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : result_serializer_pkg
`default_nettype wire

// File: rtl/result_serializer_if.sv
`default_nettype none
// ============================================================================
// Module  : result_serializer_if
// Brief   : Capture/serial-out bundle; signature exists only with
//           RESULT_SERIALIZER_MISR_EN defined.
// Rev     : 1.0 - initial release
// ============================================================================
interface result_serializer_if #(
    parameter int WIDTH = result_serializer_pkg::RS_WIDTH
);
    logic [WIDTH-1:0] dst;          // dst[0] is dst0 (LSB)
    logic             capture;
    logic             busy;
    logic             dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             done;
`ifdef RESULT_SERIALIZER_MISR_EN
    logic [WIDTH-1:0] signature;
`endif

    modport master (
        input  dst, capture, dout_ready,
        output busy, dout, dout_valid, done
`ifdef RESULT_SERIALIZER_MISR_EN
        , output signature
`endif
    );

    modport slave (
        output dst, capture, dout_ready,
        input  busy, dout, dout_valid, done
`ifdef RESULT_SERIALIZER_MISR_EN
        , input signature
`endif
    );

endinterface : result_serializer_if
`default_nettype wire

// File: rtl/result_serializer_misr_serial.sv
`default_nettype none
// ============================================================================
// Module  : misr_serial
// Brief   : Single-input MISR; folds one bit into bit 0 per enabled cycle.
// Rev     : 1.0 - initial release
// ============================================================================
module misr_serial
    import result_serializer_pkg::*;
#(
    parameter int               WIDTH = RS_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_POLY)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             en,
    input  wire logic             din,
    output logic      [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] r_sig;
    logic [WIDTH-1:0] w_fb;

    assign w_fb = r_sig[WIDTH-1] ? POLY : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (en) begin
            r_sig <= {r_sig[WIDTH-2:0], 1'b0} ^ w_fb ^ {{(WIDTH-1){1'b0}}, din};
        end
    end

    assign sig = r_sig;

endmodule : misr_serial
`default_nettype wire

// File: rtl/result_serializer.sv
`default_nettype none
// ============================================================================
// Module  : result_serializer
// Brief   : Latches a WIDTH-bit result and shifts it out LSB first over a
//           valid/ready link. Optional MISR: RESULT_SERIALIZER_MISR_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int WIDTH = RS_WIDTH,
    parameter int CNT_W = 6
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    result_serializer_if.master bus
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic             w_xfer;
    logic             w_last;
    logic             w_load;

    assign w_xfer = (r_state == ST_SHIFT) && bus.dout_ready;
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_load = (r_state == ST_IDLE) && bus.capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.capture)     w_next = ST_SHIFT;
            ST_SHIFT: if (w_xfer && w_last) w_next = ST_DONE;
            ST_DONE:                        w_next = ST_IDLE;
            default:                        w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = 1'b0;
        bus.dout       = 1'b0;
        bus.dout_valid = 1'b0;
        bus.done       = 1'b0;
        case (r_state)
            ST_SHIFT: begin
                bus.busy       = 1'b1;
                bus.dout       = r_sreg[0];
                bus.dout_valid = 1'b1;
            end
            ST_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    // Shift register and bit counter only move on an accepted bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (w_load) begin
            r_sreg <= bus.dst;
            r_cnt  <= '0;
        end else if (w_xfer) begin
            r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

`ifdef RESULT_SERIALIZER_MISR_EN
    misr_serial #(
        .WIDTH (WIDTH),
        .POLY  (WIDTH'(MISR_POLY))
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_xfer),
        .din   (r_sreg[0]),
        .sig   (bus.signature)
    );
`endif

endmodule : result_serializer
`default_nettype wire

// File: tb/tb_result_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_result_serializer
// Brief   : Randomized and directed bench against a queue-based frame model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_result_serializer;
    import result_serializer_pkg::*;

    localparam int W = RS_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    result_serializer_if #(.WIDTH(W)) bus ();

    result_serializer #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int total = 0;
    int bad   = 0;

    // Model: bits still to be delivered, plus the one-cycle completion flag.
    logic q[$];
    bit   m_done;
`ifdef RESULT_SERIALIZER_MISR_EN
    logic [W-1:0] m_sig;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_done = 1'b0;
`ifdef RESULT_SERIALIZER_MISR_EN
        m_sig = '0;
`endif
    endtask

    task automatic model_edge(input logic cap, input logic rdy, input logic [W-1:0] d);
        logic b;
        if (m_done) begin
            m_done = 1'b0;
        end else if (q.size() > 0) begin
            if (rdy) begin
                b = q.pop_front();
`ifdef RESULT_SERIALIZER_MISR_EN
                m_sig = {m_sig[W-2:0], 1'b0} ^ (m_sig[W-1] ? W'(MISR_POLY) : '0)
                        ^ {{(W-1){1'b0}}, b};
`endif
                if (q.size() == 0) m_done = 1'b1;
            end
        end else if (cap) begin
            for (int i = 0; i < W; i++) q.push_back(d[i]);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".busy"},  64'(bus.busy),       64'((q.size() > 0) || m_done));
        chk({tag, ".valid"}, 64'(bus.dout_valid), 64'(q.size() > 0));
        chk({tag, ".dout"},  64'(bus.dout),       64'((q.size() > 0) ? q[0] : 1'b0));
        chk({tag, ".done"},  64'(bus.done),       64'(m_done));
`ifdef RESULT_SERIALIZER_MISR_EN
        chk({tag, ".sig"},   64'(bus.signature),  64'(m_sig));
`endif
    endtask

    task automatic cycle(input string tag, input logic cap, input logic rdy, input logic [W-1:0] d);
        bus.capture    = cap;
        bus.dout_ready = rdy;
        bus.dst        = d;
        @(posedge clk);
        model_edge(cap, rdy, d);
        #1;
        check_outs(tag);
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int done_idx;
        int done_cnt;
        logic [W-1:0] d;

        bus.capture    = 1'b0;
        bus.dout_ready = 1'b0;
        bus.dst        = '0;
        model_reset();
        #2;
        check_outs("reset");
        #10;
        rst_n = 1'b1;

        // Lone bits at both ends, ready held high; done lands on cycle 34.
        done_idx = -1;
        cycle("edge", 1'b1, 1'b1, 33'h1_0000_0001);
        for (int i = 2; i <= 36; i++) begin
            cycle("edge", 1'b0, 1'b1, '0);
            if (bus.done === 1'b1 && done_idx < 0) done_idx = i;
        end
        chk("edge.done_cycle", 64'(done_idx), 64'd34);

        // MISR starting from reset: a single 1 ends up at the MSB.
        pulse_reset("rst_misr");
        cycle("misr1", 1'b1, 1'b1, 33'h0_0000_0001);
        for (int i = 0; i < 35; i++) cycle("misr1", 1'b0, 1'b1, '0);
`ifdef RESULT_SERIALIZER_MISR_EN
        chk("misr1.sig_const", 64'(bus.signature), 64'h1_0000_0000);
`endif
        cycle("misr2", 1'b1, 1'b1, 33'h0_0000_0001);
        for (int i = 0; i < 35; i++) cycle("misr2", 1'b0, 1'b1, '0);

        // Alternating pattern with ready toggling.
        done_cnt = 0;
        cycle("alt", 1'b1, 1'b1, 33'h0_AAAA_AAAA);
        for (int k = 1; k < 72; k++) begin
            cycle("alt", 1'b0, (k % 2) == 0, '0);
            if (bus.done === 1'b1) done_cnt++;
        end
        chk("alt.done_count", 64'(done_cnt), 64'd1);

        // Capture held high across frames.
        done_cnt = 0;
        for (int k = 0; k < 80; k++) begin
            cycle("hold", 1'b1, 1'b1, 33'h1_2345_6789 ^ W'(k));
            if (bus.done === 1'b1) done_cnt++;
        end
        chk("hold.done_count", 64'(done_cnt), 64'd2);

        // Reset after 10 transfers abandons the frame.
        d = W'({$urandom(), $urandom()});
        cycle("midrst", 1'b1, 1'b1, d);
        for (int k = 1; k < 10; k++) cycle("midrst", 1'b0, 1'b1, '0);
        @(posedge clk);
        model_edge(1'b0, 1'b1, '0);
        #1;
        pulse_reset("midrst.rst");
        d = W'({$urandom(), $urandom()});
        cycle("restart", 1'b1, 1'b1, d);
        for (int k = 0; k < 36; k++) cycle("restart", 1'b0, 1'b1, '0);

        // Randomized capture/ready traffic.
        for (int k = 0; k < 600; k++) begin
            d = W'({$urandom(), $urandom()});
            cycle("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_result_serializer
`default_nettype wire

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 Parameter WIDTH, default 33: number of compressor result bits captured per frame.
REQ-002 Parameter CNT_W, default 6: bit-counter width; SHALL satisfy 2**CNT_W >= WIDTH.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 dst0..dst32  input  1 each  compressor result bits, dst0 = LSB (weight 2^0).
REQ-006 capture  input  1  request to latch the current dst0..dst32 bits.
REQ-007 busy  output  1  high while a frame is being shifted out or completing.
REQ-008 dout  output  1  current serial bit, LSB first.
REQ-009 dout_valid  output  1  dout holds a valid bit.
REQ-010 dout_ready  input  1  downstream accepts dout this cycle.
REQ-011 done  output  1  one-cycle pulse after the last bit of a frame is accepted.
REQ-012 signature  output  WIDTH  running MISR value (present only when RESULT_SERIALIZER_MISR_EN is defined).

Function
REQ-013 FSM states: IDLE, SHIFT, DONE.
REQ-014 IDLE: capture=1 SHALL load {dst32..dst0} into shift register sreg, clear bit counter cnt to 0, and go to SHIFT on the next edge.
REQ-015 capture SHALL be ignored in SHIFT and DONE; no frame is queued.
REQ-016 SHIFT: dout = sreg[0], dout_valid = 1, busy = 1.
REQ-017 Handshake: a bit is transferred on a cycle where dout_valid & dout_ready; only then sreg shifts right by one (zero fill) and cnt increments.
REQ-018 dout_ready low SHALL hold dout, sreg and cnt unchanged for any number of cycles.
REQ-019 Transfer with cnt == WIDTH-1 SHALL move to DONE; exactly WIDTH bits are transferred per frame.
REQ-020 DONE: done = 1, busy = 1, dout_valid = 0 for exactly one cycle, then IDLE unconditionally.
REQ-021 IDLE: busy = 0, dout_valid = 0, done = 0, dout = 0.
REQ-022 Capture-to-first-valid latency: 1 cycle; best-case frame time from capture to done: WIDTH+1 cycles.
REQ-023 capture asserted in the DONE cycle SHALL be ignored; capture in the following IDLE cycle is accepted.

Reset
REQ-024 rst_n low SHALL asynchronously force state = IDLE, sreg = 0, cnt = 0, signature = 0; outputs busy, dout, dout_valid, done = 0.
REQ-025 Reset mid-frame SHALL abandon the frame; no done pulse is produced for it.
REQ-026 After rst_n deasserts, the first capture is accepted on the first posedge with rst_n high.

Configuration
REQ-027 Macro RESULT_SERIALIZER_MISR_EN defined: signature port exists; on each transferred bit b, signature <= (signature << 1) ^ (signature[WIDTH-1] ? MISR_POLY : 0) ^ b (b XORed into bit 0); cleared only by reset, accumulates across frames.
REQ-028 Macro undefined: no signature port, no MISR registers; all other behaviour identical.

Structure
REQ-029 Package result_serializer_pkg SHALL hold the state enum type, RS_WIDTH = 33 and MISR_POLY (33-bit constant, x^33 + x^13 + 1 taps, value 33'h0_0000_2001).
REQ-030 The MISR SHALL be a separate sub-module misr_serial (ports clk, rst_n, en, din, sig), instantiated only under RESULT_SERIALIZER_MISR_EN.

Verification
REQ-031 dst = 33'h1_0000_0001, capture, dout_ready tied high -> dout sequence 1, 31x0, 1 on cycles 1..33; done pulses on cycle 34; busy low cycle 35.
REQ-032 dst = 33'h0_AAAA_AAAA, dout_ready toggling 1,0,1,0 -> dout stable while ready low; 33 transfers delivered 0,1,0,1,...,0; done once after the 33rd transfer.
REQ-033 capture held high throughout a frame -> second frame starts only after DONE + one IDLE cycle; no extra done pulses.
REQ-034 rst_n pulsed low after 10 transfers -> busy, dout_valid, done drop immediately; no done; next capture restarts at bit 0.
REQ-035 With RESULT_SERIALIZER_MISR_EN: one frame of dst = 33'h0_0000_0001 from reset -> signature = 33'h1_0000_0000 after done (lone 1 shifted to MSB, no feedback); second identical frame -> signature matches reference model value.
REQ-036 Without RESULT_SERIALIZER_MISR_EN: build compiles with no signature port; REQ-031 stimulus gives identical dout/done trace.
